// File: rtl/cpu_scoreboard.sv
// Register scoreboard / interlock: per-register pending-write counters, RAW stall,
// optional same-cycle writeback forwarding enabled by macro CPU_SCOREBOARD_FORWARD_EN.
module cpu_scoreboard #(
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  input  logic                    issue_we_i,
  input  logic [IDX_W-1:0]        issue_widx_i,
  input  logic [1:0]              rd_en_i,
  input  logic [IDX_W-1:0]        rd_idx1_i,
  input  logic [IDX_W-1:0]        rd_idx2_i,
  input  logic                    wb_valid_i,
  input  logic [IDX_W-1:0]        wb_idx_i,
  input  logic [DATA_W-1:0]       wb_data_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic [NREGS-1:0]        busy_o,
  output logic [IDX_W+PEND_W-1:0] outstanding_o,
  output logic [1:0]              fwd_valid_o,
  output logic [DATA_W-1:0]       fwd_data1_o,
  output logic [DATA_W-1:0]       fwd_data2_o,
  output logic                    underflow_o
);

  localparam int IDX_SPACE = 2 ** IDX_W;
  localparam int OUT_W     = IDX_W + PEND_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0]    cnt_q    [NREGS];
  logic [PEND_W-1:0]    cnt_d    [NREGS];
  logic [PEND_W-1:0]    cnt_view [IDX_SPACE];
  logic [IDX_SPACE-1:0] reg_ok;
  logic [NREGS-1:0]     inc_v;
  logic [NREGS-1:0]     dec_v;
  logic [NREGS-1:0]     busy_d;
  logic [OUT_W-1:0]     out_d;
  logic [NREGS-1:0]     busy_q;
  logic [OUT_W-1:0]     out_q;
  logic                 underflow_q;

  logic [PEND_W-1:0] cnt_a;
  logic [PEND_W-1:0] cnt_b;
  logic              hit1;
  logic              hit2;
  logic              fwd1;
  logic              fwd2;
  logic              sat;
  logic              accept;
  logic              wb_hit;
  logic              underflow_set;

  // Full index space view: indices beyond NREGS read as never pending.
  for (genvar g = 0; g < IDX_SPACE; g++) begin : g_view
    if (g < NREGS) begin : g_real
      assign cnt_view[g] = cnt_q[g];
      assign reg_ok[g]   = 1'b1;
    end else begin : g_pad
      assign cnt_view[g] = '0;
      assign reg_ok[g]   = 1'b0;
    end
  end

  assign cnt_a = cnt_view[rd_idx1_i];
  assign cnt_b = cnt_view[rd_idx2_i];
  assign hit1  = rd_en_i[0] & (cnt_a != '0);
  assign hit2  = rd_en_i[1] & (cnt_b != '0);
  assign sat   = issue_valid_i & issue_we_i & (cnt_view[issue_widx_i] == CNT_MAX);

`ifdef CPU_SCOREBOARD_FORWARD_EN
  // Only the last outstanding write may be bypassed; older writes still stall.
  assign fwd1        = hit1 & wb_valid_i & (wb_idx_i == rd_idx1_i) & (cnt_a == CNT_ONE);
  assign fwd2        = hit2 & wb_valid_i & (wb_idx_i == rd_idx2_i) & (cnt_b == CNT_ONE);
  assign fwd_data1_o = fwd1 ? wb_data_i : '0;
  assign fwd_data2_o = fwd2 ? wb_data_i : '0;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_i;
  assign fwd1           = 1'b0;
  assign fwd2           = 1'b0;
  assign fwd_data1_o    = '0;
  assign fwd_data2_o    = '0;
`endif

  assign fwd_valid_o = {fwd2, fwd1};

  // Issue handshake: an instruction transfers when issue_valid_i is high and
  // stall_o is low (stall_o is the inverted ready); flush_i squashes the transfer.
  assign stall_o = (hit1 & ~fwd1) | (hit2 & ~fwd2) | sat;
  assign accept  = issue_valid_i & ~stall_o & ~flush_i;

  assign wb_hit        = wb_valid_i & reg_ok[wb_idx_i] & ~flush_i;
  assign underflow_set = wb_hit & (cnt_view[wb_idx_i] == '0);

  always_comb begin
    inc_v  = '0;
    dec_v  = '0;
    busy_d = '0;
    out_d  = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc_v[r] = accept & issue_we_i & (issue_widx_i == IDX_W'(r));
      dec_v[r] = wb_hit & (wb_idx_i == IDX_W'(r)) & (cnt_q[r] != '0);
      if (flush_i) begin
        cnt_d[r] = '0;
      end else begin
        cnt_d[r] = cnt_q[r] + PEND_W'(inc_v[r]) - PEND_W'(dec_v[r]);
      end
      busy_d[r] = (cnt_d[r] != '0);
      out_d     = out_d + OUT_W'(cnt_d[r]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q      <= '0;
      out_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
      out_q  <= out_d;
      if (underflow_set) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign busy_o        = busy_q;
  assign outstanding_o = out_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed bench for cpu_scoreboard: reset, RAW stall, multi-write, simultaneous
// issue/writeback, underflow and flush; forwarding checks follow CPU_SCOREBOARD_FORWARD_EN.
module tb_cpu_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_we_i;
  logic [3:0]  issue_widx_i;
  logic [1:0]  rd_en_i;
  logic [3:0]  rd_idx1_i;
  logic [3:0]  rd_idx2_i;
  logic        wb_valid_i;
  logic [3:0]  wb_idx_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        stall_o;
  logic [15:0] busy_o;
  logic [5:0]  outstanding_o;
  logic [1:0]  fwd_valid_o;
  logic [31:0] fwd_data1_o;
  logic [31:0] fwd_data2_o;
  logic        underflow_o;

  int errors = 0;
  int checks = 0;

  cpu_scoreboard #(.NREGS(16), .IDX_W(4), .DATA_W(32), .PEND_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_widx_i(issue_widx_i),
    .rd_en_i(rd_en_i), .rd_idx1_i(rd_idx1_i), .rd_idx2_i(rd_idx2_i),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
    .outstanding_o(outstanding_o), .fwd_valid_o(fwd_valid_o),
    .fwd_data1_o(fwd_data1_o), .fwd_data2_o(fwd_data2_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_we_i = 1'b0; issue_widx_i = '0;
    rd_en_i = 2'b00; rd_idx1_i = '0; rd_idx2_i = '0;
    wb_valid_i = 1'b0; wb_idx_i = '0; wb_data_i = '0; flush_i = 1'b0;
  endtask

  task automatic issue(input logic [3:0] idx);
    issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_widx_i = idx;
  endtask

  task automatic no_issue();
    issue_valid_i = 1'b0; issue_we_i = 1'b0;
  endtask

  task automatic wb(input logic [3:0] idx, input logic [31:0] data);
    wb_valid_i = 1'b1; wb_idx_i = idx; wb_data_i = data;
  endtask

  task automatic no_wb();
    wb_valid_i = 1'b0; wb_data_i = '0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_outstanding", 64'(outstanding_o), 64'h0);
    chk("rst_underflow", 64'(underflow_o), 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_fwd_valid", 64'(fwd_valid_o), 64'h0);
    rst_i = 1'b1;

    // RAW stall on r5, port A
    issue(4'd5);
    #1 chk("raw_issue_stall", 64'(stall_o), 64'h0);
    tick();
    no_issue();
    chk("raw_outstanding", 64'(outstanding_o), 64'h1);
    chk("raw_busy", 64'(busy_o), 64'h0020);
    rd_en_i = 2'b01; rd_idx1_i = 4'd5;
    #1 chk("raw_stall_read", 64'(stall_o), 64'h1);
    tick();
    chk("raw_stall_hold", 64'(stall_o), 64'h1);
    wb(4'd5, 32'hDEADBEEF);
    #1;
`ifdef CPU_SCOREBOARD_FORWARD_EN
    chk("raw_wb_stall", 64'(stall_o), 64'h0);
    chk("raw_fwd_valid", 64'(fwd_valid_o), 64'h1);
    chk("raw_fwd_data1", 64'(fwd_data1_o), 64'hDEADBEEF);
`else
    chk("raw_wb_stall", 64'(stall_o), 64'h1);
    chk("raw_fwd_valid", 64'(fwd_valid_o), 64'h0);
    chk("raw_fwd_data1", 64'(fwd_data1_o), 64'h0);
`endif
    tick();
    no_wb();
    #1 chk("raw_after_wb_stall", 64'(stall_o), 64'h0);
    chk("raw_after_wb_busy", 64'(busy_o), 64'h0);
    chk("raw_after_wb_outstanding", 64'(outstanding_o), 64'h0);
    idle();

    // Three writes to r2 in flight, fourth saturates
    issue(4'd2);
    tick(); tick(); tick();
    chk("multi_outstanding3", 64'(outstanding_o), 64'h3);
    chk("multi_busy", 64'(busy_o), 64'h0004);
    #1 chk("multi_sat_stall", 64'(stall_o), 64'h1);
    tick();
    chk("multi_sat_hold", 64'(outstanding_o), 64'h3);
    wb(4'd2, 32'h1);
    tick();
    no_wb();
    chk("multi_after_wb", 64'(outstanding_o), 64'h2);
    #1 chk("multi_unstall", 64'(stall_o), 64'h0);
    tick();
    no_issue();
    chk("multi_fourth_accepted", 64'(outstanding_o), 64'h3);
    wb(4'd2, 32'h2);
    tick(); tick(); tick();
    no_wb();
    chk("multi_drained", 64'(outstanding_o), 64'h0);
    chk("multi_no_underflow", 64'(underflow_o), 64'h0);

    // Issue and writeback on r7 in the same cycle
    issue(4'd7);
    tick();
    chk("simul_setup", 64'(outstanding_o), 64'h1);
    wb(4'd7, 32'h7);
    tick();
    no_issue(); no_wb();
    chk("simul_outstanding", 64'(outstanding_o), 64'h1);
    chk("simul_busy", 64'(busy_o), 64'h0080);
    wb(4'd7, 32'h7);
    tick();
    no_wb();
    chk("simul_drained", 64'(outstanding_o), 64'h0);

    // Underflow on r9, sticky
    wb(4'd9, 32'h9);
    tick();
    no_wb();
    chk("underflow_set", 64'(underflow_o), 64'h1);
    chk("underflow_cnt", 64'(outstanding_o), 64'h0);
    tick();
    chk("underflow_sticky", 64'(underflow_o), 64'h1);

    // Flush with concurrent issue and writeback
    issue(4'd1); tick();
    issue(4'd4); tick();
    chk("flush_setup_out", 64'(outstanding_o), 64'h2);
    chk("flush_setup_busy", 64'(busy_o), 64'h0012);
    issue(4'd6); wb(4'd1, 32'h1); flush_i = 1'b1;
    tick();
    idle();
    chk("flush_outstanding", 64'(outstanding_o), 64'h0);
    chk("flush_busy", 64'(busy_o), 64'h0);
    chk("flush_underflow_kept", 64'(underflow_o), 64'h1);

    // Port B read of r3 with two writes pending
    issue(4'd3); tick(); tick();
    no_issue();
    chk("portb_setup", 64'(outstanding_o), 64'h2);
    rd_en_i = 2'b10; rd_idx2_i = 4'd3;
    wb(4'd3, 32'hCAFE0001);
    #1 chk("portb_cnt2_stall", 64'(stall_o), 64'h1);
    chk("portb_cnt2_fwd", 64'(fwd_valid_o), 64'h0);
    tick();
    chk("portb_cnt1", 64'(outstanding_o), 64'h1);
    wb(4'd3, 32'hCAFE0002);
    #1;
`ifdef CPU_SCOREBOARD_FORWARD_EN
    chk("portb_fwd_stall", 64'(stall_o), 64'h0);
    chk("portb_fwd_valid", 64'(fwd_valid_o), 64'h2);
    chk("portb_fwd_data2", 64'(fwd_data2_o), 64'hCAFE0002);
`else
    chk("portb_fwd_stall", 64'(stall_o), 64'h1);
    chk("portb_fwd_valid", 64'(fwd_valid_o), 64'h0);
    chk("portb_fwd_data2", 64'(fwd_data2_o), 64'h0);
`endif
    tick();
    no_wb();
    #1 chk("portb_clear", 64'(stall_o), 64'h0);
    idle();

    // Asynchronous reset mid-run with cnt[3]=2
    issue(4'd3); tick(); tick();
    no_issue();
    chk("areset_setup", 64'(outstanding_o), 64'h2);
    rd_en_i = 2'b01; rd_idx1_i = 4'd3;
    #1 chk("areset_pre_stall", 64'(stall_o), 64'h1);
    rst_i = 1'b0;
    #1;
    chk("areset_busy", 64'(busy_o), 64'h0);
    chk("areset_outstanding", 64'(outstanding_o), 64'h0);
    chk("areset_underflow", 64'(underflow_o), 64'h0);
    chk("areset_stall", 64'(stall_o), 64'h0);
    tick();
    rst_i = 1'b1;
    idle();
    tick();
    chk("post_reset_idle", 64'(outstanding_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
